// File: rtl/axi_rd_to_lint64.sv
// -----------------------------------------------------------------------------
// axi_rd_to_lint64
//
// Purpose:
//   Converts one AXI4 read burst at a time into a sequence of 64-bit or 32-bit
//   LINT read requests, one per beat. LINT responses cannot be backpressured,
//   so they land in a response FIFO whose free slots are tracked as credits.
//   A request is only issued while a free slot is guaranteed. The FIFO is
//   drained onto the AXI R channel with RID/RLAST regenerated locally.
//
// Optional feature (macro AXI_RD_ADDR_CHECK_EN):
//   Bursts whose start address falls outside the window ADDR_BASE/ADDR_MASK
//   issue no LINT requests. They are answered with len+1 SLVERR beats of zero
//   data. ADDR_BASE and ADDR_MASK exist only in this build.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ar_*            AXI4 read address channel (valid/ready, addr, len, size,
//                   burst, id)
//   r_*             AXI4 read data channel (valid/ready, data, resp, last, id)
//   data_req_o ..   LINT request side (req/gnt, byte address, wen=1, wdata=0,
//   data_size_o     byte enables, size: 1 = 64-bit, 0 = 32-bit)
//   data_r_*        LINT response side (valid with no backpressure, rdata)
// -----------------------------------------------------------------------------
module axi_rd_to_lint64 #(
    parameter int          ID_WIDTH   = 4,
    parameter int          RESP_DEPTH = 4
`ifdef AXI_RD_ADDR_CHECK_EN
    ,
    parameter logic [31:0] ADDR_BASE  = 32'h1C00_0000,
    parameter logic [31:0] ADDR_MASK  = 32'hFFF8_0000
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ar_valid,
    output logic                ar_ready,
    input  logic [31:0]         ar_addr,
    input  logic [7:0]          ar_len,
    input  logic [2:0]          ar_size,
    input  logic [1:0]          ar_burst,
    input  logic [ID_WIDTH-1:0] ar_id,
    output logic                r_valid,
    input  logic                r_ready,
    output logic [63:0]         r_data,
    output logic [1:0]          r_resp,
    output logic                r_last,
    output logic [ID_WIDTH-1:0] r_id,
    output logic                data_req_o,
    input  logic                data_gnt_i,
    output logic [31:0]         data_add_o,
    output logic                data_wen_o,
    output logic [63:0]         data_wdata_o,
    output logic [7:0]          data_be_o,
    output logic                data_size_o,
    input  logic                data_r_valid_i,
    input  logic [63:0]         data_r_rdata_i
);

    localparam int PW = $clog2(RESP_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
`ifdef AXI_RD_ADDR_CHECK_EN
        ,
        S_ERR
`endif
    } state_t;

    state_t                r_state, w_state_nxt;
    logic                  r_ar_en;
    logic [31:0]           r_addr;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic [ID_WIDTH-1:0]   r_id_lat;
    logic [7:0]            r_issue_cnt;
    logic [7:0]            r_ret_cnt;
    logic [CW-1:0]         r_credits;
    logic [PW:0]           r_wptr, r_rptr;
    logic [63:0]           r_mem [RESP_DEPTH];

    logic                  w_ar_hs, w_grant, w_push, w_pop, w_r_hs;
    logic                  w_fifo_valid, w_in_err;
    logic [CW-1:0]         w_count, w_outstanding;
    logic [31:0]           w_step, w_aligned, w_incr, w_wrap_mask, w_wrap;
    logic [31:0]           w_next_addr, w_lint_addr;
    logic [7:0]            w_be;
    logic                  w_size64;

    // ar_ready is held low for the first cycle after reset so every output
    // shows its reset value on that cycle.
    assign ar_ready   = (r_state == S_IDLE) && r_ar_en;
    assign w_ar_hs    = ar_valid && ar_ready;
    assign data_req_o = (r_state == S_ISSUE) && (r_credits != '0);
    assign w_grant    = data_req_o && data_gnt_i;

    // Slots consumed = entries held + reads still in flight. A response that
    // arrives with nothing in flight is stale (issued before a reset) and is
    // dropped.
    assign w_count       = r_wptr - r_rptr;
    assign w_outstanding = CW'(RESP_DEPTH) - r_credits - w_count;
    assign w_fifo_valid  = (w_count != '0);
    assign w_push        = data_r_valid_i && (w_outstanding != '0);
    assign w_pop         = w_fifo_valid && r_ready;

`ifdef AXI_RD_ADDR_CHECK_EN
    logic w_addr_ok;
    assign w_addr_ok = ((ar_addr & ADDR_MASK) == ADDR_BASE);
    assign w_in_err  = (r_state == S_ERR);
`else
    assign w_in_err  = 1'b0;
`endif

    assign r_valid = w_fifo_valid || w_in_err;
    assign r_data  = w_in_err ? 64'h0 : r_mem[r_rptr[PW-1:0]];
    assign r_resp  = w_in_err ? 2'b10 : 2'b00;
    assign r_last  = r_valid && (r_ret_cnt == 8'd0);
    assign r_id    = r_id_lat;
    assign w_r_hs  = r_valid && r_ready;

    // Address advance. WRAP keeps the bits above the (len+1)<<size boundary
    // and lets the bits inside it roll over.
    assign w_step      = 32'd1 << r_size;
    assign w_aligned   = r_addr & ~(w_step - 32'd1);
    assign w_incr      = w_aligned + w_step;
    assign w_wrap_mask = ((32'(r_len) + 32'd1) << r_size) - 32'd1;
    assign w_wrap      = (r_addr & ~w_wrap_mask) | (w_incr & w_wrap_mask);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; a missing default here would infer a latch.
        w_next_addr = w_incr;
        case (r_burst)
            2'b00:   w_next_addr = r_addr;
            2'b10:   w_next_addr = w_wrap;
            default: ;
        endcase
    end

    // Per-beat LINT shape; defaults describe a 64-bit access.
    always_comb begin
        w_size64    = 1'b1;
        w_be        = 8'hFF;
        w_lint_addr = {r_addr[31:3], 3'b000};
        case (r_size)
            3'd2: begin
                w_size64    = 1'b0;
                w_lint_addr = r_addr;
                w_be        = r_addr[2] ? 8'hF0 : 8'h0F;
            end
            3'd1: begin
                w_size64    = 1'b0;
                w_lint_addr = r_addr;
                w_be        = 8'b0000_0011 << r_addr[2:0];
            end
            3'd0: begin
                w_size64    = 1'b0;
                w_lint_addr = r_addr;
                w_be        = 8'b0000_0001 << r_addr[2:0];
            end
            default: ;
        endcase
    end

    // Request-side outputs are driven only while issuing, so they read as
    // zero outside a burst and directly after reset.
    assign data_add_o   = (r_state == S_ISSUE) ? w_lint_addr : 32'h0;
    assign data_be_o    = (r_state == S_ISSUE) ? w_be        : 8'h00;
    assign data_size_o  = (r_state == S_ISSUE) && w_size64;
    assign data_wen_o   = 1'b1;
    assign data_wdata_o = 64'h0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_ar_hs) begin
`ifdef AXI_RD_ADDR_CHECK_EN
                    w_state_nxt = w_addr_ok ? S_ISSUE : S_ERR;
`else
                    w_state_nxt = S_ISSUE;
`endif
                end
            end
            S_ISSUE: if (w_grant && (r_issue_cnt == 8'd0)) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_r_hs && r_last)                 w_state_nxt = S_IDLE;
`ifdef AXI_RD_ADDR_CHECK_EN
            S_ERR:   if (w_r_hs && r_last)                 w_state_nxt = S_IDLE;
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ar_en     <= 1'b0;
            r_addr      <= 32'h0;
            r_len       <= 8'h0;
            r_size      <= 3'h0;
            r_burst     <= 2'h0;
            r_id_lat    <= '0;
            r_issue_cnt <= 8'h0;
            r_ret_cnt   <= 8'h0;
            r_credits   <= CW'(RESP_DEPTH);
            r_wptr      <= '0;
            r_rptr      <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ar_en <= 1'b1;
            if (w_ar_hs) begin
                r_addr      <= ar_addr;
                r_len       <= ar_len;
                r_size      <= ar_size;
                r_burst     <= ar_burst;
                r_id_lat    <= ar_id;
                r_issue_cnt <= ar_len;
                r_ret_cnt   <= ar_len;
            end
            if (w_grant) begin
                r_addr      <= w_next_addr;
                r_issue_cnt <= r_issue_cnt - 8'd1;
            end
            if (w_r_hs && !r_last) r_ret_cnt <= r_ret_cnt - 8'd1;
            case ({w_grant, w_pop})
                2'b10:   r_credits <= r_credits - CW'(1);
                2'b01:   r_credits <= r_credits + CW'(1);
                default: ;
            endcase
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; only the pointers
    // define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[PW-1:0]] <= data_r_rdata_i;
    end

endmodule

// File: tb/tb_axi_rd_to_lint64.sv
// -----------------------------------------------------------------------------
// tb_axi_rd_to_lint64
//
// Directed bench for axi_rd_to_lint64. A small LINT slave model answers every
// granted request one cycle later with data {~addr, addr}; a monitor logs
// LINT handshakes and R beats so each burst can be compared against
// hand-derived address, byte-enable and sideband lists. Honors
// AXI_RD_ADDR_CHECK_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_axi_rd_to_lint64;

    logic        clk = 1'b0;
    logic        rst;
    logic        ar_valid;
    logic        ar_ready;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic [3:0]  ar_id;
    logic        r_valid;
    logic        r_ready;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic [3:0]  r_id;
    logic        data_req_o;
    logic        data_gnt_i;
    logic [31:0] data_add_o;
    logic        data_wen_o;
    logic [63:0] data_wdata_o;
    logic [7:0]  data_be_o;
    logic        data_size_o;
    logic        data_r_valid_i;
    logic [63:0] data_r_rdata_i;

    axi_rd_to_lint64 #(.ID_WIDTH(4), .RESP_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
        .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst), .ar_id(ar_id),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
        .r_last(r_last), .r_id(r_id),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_add_o(data_add_o),
        .data_wen_o(data_wen_o), .data_wdata_o(data_wdata_o), .data_be_o(data_be_o),
        .data_size_o(data_size_o), .data_r_valid_i(data_r_valid_i),
        .data_r_rdata_i(data_r_rdata_i)
    );

    always #5 clk = ~clk;

    // LINT slave: response exactly one cycle after each grant, never stalls.
    logic        lint_pend = 1'b0;
    logic [31:0] lint_addr = 32'h0;
    always @(posedge clk) begin
        lint_pend <= data_req_o & data_gnt_i;
        lint_addr <= data_add_o;
    end
    assign data_r_valid_i = lint_pend;
    assign data_r_rdata_i = {~lint_addr, lint_addr};

    // Monitor: inputs change #1 after posedge, so the negedge view is what
    // the next rising edge will see.
    logic [40:0] req_q   [$];   // {size, be, addr}
    logic [63:0] rdata_q [$];
    logic [6:0]  rside_q [$];   // {resp, last, id}
    always @(negedge clk) begin
        if (!rst) begin
            if (data_req_o && data_gnt_i) req_q.push_back({data_size_o, data_be_o, data_add_o});
            if (r_valid && r_ready) begin
                rdata_q.push_back(r_data);
                rside_q.push_back({r_resp, r_last, r_id});
            end
        end
    end

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;
    logic [40:0] exp_req [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ar_ready"}, ar_ready,    0);
        check({tag, "_r_valid"},  r_valid,     0);
        check({tag, "_r_last"},   r_last,      0);
        check({tag, "_r_resp"},   r_resp,      0);
        check({tag, "_r_id"},     r_id,        0);
        check({tag, "_req"},      data_req_o,  0);
        check({tag, "_add"},      data_add_o,  0);
        check({tag, "_be"},       data_be_o,   0);
        check({tag, "_size"},     data_size_o, 0);
    endtask

    task automatic do_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                         input logic [1:0] b, input logic [3:0] id);
        logic seen;
        seen = 1'b0;
        @(posedge clk); #1;
        ar_valid = 1'b1; ar_addr = a; ar_len = l; ar_size = s; ar_burst = b; ar_id = id;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ar_ready) begin
                seen = 1'b1;
                break;
            end
        end
        check("ar_accept", seen, 1);
        @(posedge clk); #1;
        ar_valid = 1'b0;
    endtask

    task automatic wait_beats(input string tag, input int n);
        for (int i = 0; i < 300; i++) begin
            if (rdata_q.size() >= n) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        check({tag, "_beat_count"}, rdata_q.size(), n);
    endtask

    // Compares logged LINT requests against exp_req and R beats against the
    // LINT model data for those addresses, then clears all logs.
    task automatic check_burst(input string tag, input logic [3:0] id);
        int n;
        logic [31:0] a;
        n = exp_req.size();
        check({tag, "_req_count"}, req_q.size(), n);
        for (int i = 0; i < n; i++) begin
            a = exp_req[i][31:0];
            check($sformatf("%s_req%0d", tag, i), req_q[i], exp_req[i]);
            check($sformatf("%s_data%0d", tag, i), rdata_q[i], {~a, a});
            check($sformatf("%s_side%0d", tag, i), rside_q[i], {2'b00, (i == n - 1), id});
        end
        req_q.delete(); rdata_q.delete(); rside_q.delete(); exp_req.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; ar_valid = 1'b0; ar_addr = '0; ar_len = '0; ar_size = '0;
        ar_burst = '0; ar_id = '0; r_ready = 1'b1; data_gnt_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset("reset");
        check("wen_const", data_wen_o, 1);
        check("wdata_const", data_wdata_o, 0);

        // 1: 4-beat 64-bit INCR
        exp_req = '{{1'b1, 8'hFF, 32'h1C00_0000}, {1'b1, 8'hFF, 32'h1C00_0008},
                    {1'b1, 8'hFF, 32'h1C00_0010}, {1'b1, 8'hFF, 32'h1C00_0018}};
        do_ar(32'h1C00_0000, 8'd3, 3'd3, 2'b01, 4'h5);
        wait_beats("incr64", 4);
        check_burst("incr64", 4'h5);

        // 2: 32-bit INCR from an upper-word address
        exp_req = '{{1'b0, 8'hF0, 32'h1C00_0004}, {1'b0, 8'h0F, 32'h1C00_0008}};
        do_ar(32'h1C00_0004, 8'd1, 3'd2, 2'b01, 4'h3);
        wait_beats("incr32", 2);
        check_burst("incr32", 4'h3);

        // 3: 8 beats with R stalled -> only 4 grants until credits return
        for (int i = 0; i < 8; i++) exp_req.push_back({1'b1, 8'hFF, 32'h1C00_0100 + 32'(8 * i)});
        r_ready = 1'b0;
        do_ar(32'h1C00_0100, 8'd7, 3'd3, 2'b01, 4'hA);
        repeat (20) @(negedge clk);
        #1;
        check("credit_grants", req_q.size(), 4);
        check("credit_req_low", data_req_o, 0);
        check("credit_r_valid", r_valid, 1);
        check("credit_no_beats", rdata_q.size(), 0);
        @(posedge clk); #1 r_ready = 1'b1;
        wait_beats("credit", 8);
        check_burst("credit", 4'hA);

        // 4: WRAP burst across a 32-byte boundary
        exp_req = '{{1'b1, 8'hFF, 32'h1C00_0018}, {1'b1, 8'hFF, 32'h1C00_0000},
                    {1'b1, 8'hFF, 32'h1C00_0008}, {1'b1, 8'hFF, 32'h1C00_0010}};
        do_ar(32'h1C00_0018, 8'd3, 3'd3, 2'b10, 4'h1);
        wait_beats("wrap", 4);
        check_burst("wrap", 4'h1);

        // 5: grant withheld for 5 cycles, then reset in the middle of the burst
        data_gnt_i = 1'b0;
        do_ar(32'h1C00_0040, 8'd1, 3'd2, 2'b01, 4'h6);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall_req%0d", i), data_req_o, 1);
            check($sformatf("stall_add%0d", i), data_add_o, 32'h1C00_0040);
            check($sformatf("stall_be%0d", i),  data_be_o, 8'h0F);
        end
        @(posedge clk); #1 data_gnt_i = 1'b1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_reset("mid_rst");
        repeat (3) @(negedge clk);
        check("stale_resp_dropped", r_valid, 0);
        @(posedge clk); #1;
        req_q.delete(); rdata_q.delete(); rside_q.delete();

        // single-beat burst after reset
        exp_req = '{{1'b1, 8'hFF, 32'h1C00_0200}};
        do_ar(32'h1C00_0200, 8'd0, 3'd3, 2'b01, 4'h9);
        wait_beats("len0", 1);
        check_burst("len0", 4'h9);

        // 6: address outside the legal window
`ifdef AXI_RD_ADDR_CHECK_EN
        do_ar(32'h2000_0000, 8'd2, 3'd3, 2'b01, 4'hC);
        wait_beats("err", 3);
        check("err_no_req", req_q.size(), 0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("err_data%0d", i), rdata_q[i], 64'h0);
            check($sformatf("err_side%0d", i), rside_q[i], {2'b10, (i == 2), 4'hC});
        end
        req_q.delete(); rdata_q.delete(); rside_q.delete();
`else
        exp_req = '{{1'b1, 8'hFF, 32'h2000_0000}};
        do_ar(32'h2000_0000, 8'd0, 3'd3, 2'b01, 4'hC);
        wait_beats("nochk", 1);
        check_burst("nochk", 4'hC);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
